// File: rtl/fft_twiddle_sequencer.sv
// Twiddle-factor sequencer for a radix-2 DIT FFT: walks every (stage, butterfly) slot
// of a run and streams cos / -sin looked up from a quarter-shifted sine table.
module fft_twiddle_sequencer #(
  parameter int BIT_WIDTH     = 32,
  parameter int DECIMAL_POINT = 16,
  parameter int SIZE_FFT      = 256,
  localparam int LOG_N        = $clog2(SIZE_FFT),
  localparam int STAGE_W      = $clog2(LOG_N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] sine_wave_in [0:SIZE_FFT-1],
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] twiddle_real,
  output logic [BIT_WIDTH-1:0] twiddle_imag,
  output logic [STAGE_W-1:0]   stage,
  output logic [LOG_N-2:0]     bfly,
  output logic                 done
);

  if ((SIZE_FFT < 4) || ((SIZE_FFT & (SIZE_FFT - 1)) != 0) || (DECIMAL_POINT >= BIT_WIDTH))
  begin : g_bad_params
    $error("SIZE_FFT must be a power of two >= 4 and DECIMAL_POINT below BIT_WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LOG_N-2:0]   J_LAST  = '1;
  localparam logic [LOG_N-2:0]   J_ONE   = (LOG_N-1)'(1);
  localparam logic [STAGE_W-1:0] S_LAST  = STAGE_W'(LOG_N - 1);
  localparam logic [STAGE_W-1:0] S_ONE   = STAGE_W'(1);
  localparam logic [LOG_N-1:0]   QUARTER = LOG_N'(SIZE_FFT / 4);
  localparam logic [LOG_N-1:0]   HALF    = LOG_N'(SIZE_FFT / 2);

  state_t                     state_q, state_d;
  logic [STAGE_W-1:0]         s_q, s_d;
  logic [LOG_N-2:0]           j_q, j_d;
  logic                       load;
  logic                       done_d, done_q;
  logic [LOG_N-1:0]           idx, idx_re, idx_im;
  logic signed [BIT_WIDTH-1:0] re_p1, im_p1;
  logic                       vld_p1;

  // idx = (j mod 2^s) << (log2N-1-s): the mask keeps the low s bits of j.
  function automatic logic [LOG_N-1:0] twiddle_idx(input logic [STAGE_W-1:0] s,
                                                   input logic [LOG_N-2:0]   j);
    logic [LOG_N-2:0]   mask;
    logic [STAGE_W-1:0] sh;
    mask = ~({(LOG_N-1){1'b1}} << s);
    sh   = S_LAST - s;
    return {1'b0, j & mask} << sh;
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (recv_val) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (send_rdy) begin
          if (j_q != J_LAST) begin
            j_d  = j_q + J_ONE;
            load = 1'b1;
          end else if (s_q != S_LAST) begin
            j_d  = '0;
            s_d  = s_q + S_ONE;
            load = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // cos(x) = sin(x + pi/2) and -sin(x) = sin(x + pi); the adds wrap at N.
    idx    = twiddle_idx(s_d, j_d);
    idx_re = idx + QUARTER;
    idx_im = idx + HALF;
  end

  // Stage p1: counters and looked-up twiddle registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
      re_p1   <= '0;
      im_p1   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      done_q  <= done_d;
      if (load) begin
        re_p1 <= sine_wave_in[idx_re];
        im_p1 <= sine_wave_in[idx_im];
      end
    end
  end

  assign vld_p1       = (state_q == RUN);
  assign send_val     = vld_p1;
  assign recv_rdy     = (state_q == IDLE);
  assign twiddle_real = re_p1;
  assign twiddle_imag = im_p1;
  assign stage        = s_q;
  assign bfly         = j_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Randomized bench for fft_twiddle_sequencer: backpressure, restarts and aborts checked
// against an arithmetic model of the twiddle walk.
module tb_fft_twiddle_sequencer;

  localparam int N     = 256;
  localparam int HALFN = N / 2;
  localparam int TOTAL = HALFN * 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        recv_val = 1'b0;
  logic        send_rdy = 1'b0;
  logic [31:0] sine [0:N-1];
  logic        recv_rdy, send_val, done;
  logic [31:0] twiddle_real, twiddle_imag;
  logic [2:0]  stage;
  logic [6:0]  bfly;

  int vectors = 0;
  int miscompares = 0;

  fft_twiddle_sequencer #(.BIT_WIDTH(32), .DECIMAL_POINT(16), .SIZE_FFT(N)) dut (
    .clk(clk), .reset(reset), .sine_wave_in(sine),
    .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_val(send_val), .send_rdy(send_rdy),
    .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
    .stage(stage), .bfly(bfly), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Table index of the twiddle for the n-th handshake of a run.
  function automatic int exp_idx(input int n);
    int s, j, h;
    s = n / HALFN;
    j = n % HALFN;
    h = 1 << s;
    return (j % h) * (N / (2 * h));
  endfunction

  task automatic check_idle_reset(input string tag);
    check({tag, "_recv_rdy"}, int'(recv_rdy), 1);
    check({tag, "_send_val"}, int'(send_val), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_real"}, $signed(twiddle_real), 0);
    check({tag, "_imag"}, $signed(twiddle_imag), 0);
    check({tag, "_stage"}, int'(stage), 0);
    check({tag, "_bfly"}, int'(bfly), 0);
  endtask

  task automatic spot(input int n);
    case (n)
      0:    begin check("spot0_real", $signed(twiddle_real), 65536);
                  check("spot0_imag", $signed(twiddle_imag), 0); end
      129:  begin check("spot_s1j1_real", $signed(twiddle_real), 0);
                  check("spot_s1j1_imag", $signed(twiddle_imag), -65536); end
      928:  begin check("spot_s7j32_real", $signed(twiddle_real), 46340);
                  check("spot_s7j32_imag", $signed(twiddle_imag), -46340); end
      960:  begin check("spot_s7j64_real", $signed(twiddle_real), 0);
                  check("spot_s7j64_imag", $signed(twiddle_imag), -65536); end
      1023: begin check("spot_last_real", $signed(twiddle_real), -65516);
                  check("spot_last_imag", $signed(twiddle_imag), -1608); end
      default: ;
    endcase
  endtask

  task automatic run(input bit random_rdy, input bit hold_val, input int abort_at,
                     input bit started, input bit spots);
    int n, cyc, idx;
    if (!started) begin
      @(negedge clk);
      check("start_recv_rdy", int'(recv_rdy), 1);
      recv_val = 1'b1;
    end
    @(negedge clk);
    if (!hold_val) recv_val = 1'b0;
    n = 0;
    cyc = 0;
    while (n < TOTAL && cyc < 8000) begin
      idx = exp_idx(n);
      check("send_val", int'(send_val), 1);
      check("recv_rdy_run", int'(recv_rdy), 0);
      check("done_run", int'(done), 0);
      check("stage", int'(stage), n / HALFN);
      check("bfly", int'(bfly), n % HALFN);
      check("real", $signed(twiddle_real), $signed(sine[(idx + N/4) % N]));
      check("imag", $signed(twiddle_imag), $signed(sine[(idx + N/2) % N]));
      if (spots) spot(n);
      if (n == abort_at) begin
        send_rdy = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_rdy = 1'b0;
        check_idle_reset("abort");
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        check("abort_idle", int'(recv_rdy), 1);
        return;
      end
      send_rdy = random_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (send_rdy) n++;
    end
    send_rdy = 1'b0;
    check("handshakes", n, TOTAL);
    if (!random_rdy) check("run_cycles", cyc, TOTAL);
    check("end_send_val", int'(send_val), 0);
    check("done_pulse", int'(done), 1);
    check("end_recv_rdy", int'(recv_rdy), 1);
    if (!hold_val) begin
      @(negedge clk);
      check("done_clear", int'(done), 0);
      check("idle_send_val", int'(send_val), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      sine[i] = 32'($rtoi($sin(2.0 * 3.14159265358979 * i / N) * 65536.0));
    repeat (2) @(negedge clk);
    check_idle_reset("reset");
    reset = 1'b0;

    run(1'b0, 1'b0, -1, 1'b0, 1'b1);   // full-rate run
    run(1'b1, 1'b1, -1, 1'b0, 1'b1);   // backpressure, recv_val held high
    run(1'b0, 1'b0, 500, 1'b1, 1'b1);  // back-to-back restart, then abort
    run(1'b1, 1'b0, -1, 1'b0, 1'b1);   // fresh start after abort

    @(negedge clk);
    for (int i = 0; i < N; i++) sine[i] = $urandom;
    run(1'b1, 1'b0, -1, 1'b0, 1'b0);   // arbitrary table exposes index errors

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
